fifo_rd_unpacker: RTL and testbench
===================================

Name: fifo_rd_unpacker

Overview:
- Read-side consumer sitting directly downstream of the async FIFO, in the read clock domain.
- Drives the FIFO read enable from the empty flag and pops DATASIZE-bit entries.
- Packs LANES consecutive entries into one wide word, first popped entry in the lowest lane.
- Presents each word to a downstream sink over a valid/ready handshake. A flush request emits any partial word with a lane count.

Parameters:
- DATASIZE, 8, width of one FIFO entry.
- LANES, 4, entries per output word; power of two, at least 2.
- CNTW, 3, width of lane counter and o_word_bytes; must hold the value LANES.

Ports:
- i_rd_clk  in  1  read clock, shared with the FIFO read side.
- i_rd_rst_n  in  1  reset; synchronous, active-low.
- i_empty  in  1  FIFO empty flag.
- i_rd_data  in  DATASIZE  FIFO read data; valid in the cycle after the pop.
- o_rd_en  out  1  FIFO pop request.
- o_word  out  DATASIZE*LANES  packed output word.
- o_word_bytes  out  CNTW  number of valid lanes in o_word (1..LANES).
- o_word_valid  out  1  o_word holds a word.
- i_word_ready  in  1  sink accepts the word on this edge when valid.
- i_flush  in  1  single-cycle request to emit any partial word.
- o_flush_done  out  1  one-cycle pulse when a flush completes.

Behaviour:
- Reset (i_rd_rst_n=0 at a rising edge):
  - All of these clear to 0: o_word, o_word_bytes, o_word_valid, o_flush_done, accumulator, acc_cnt, inflight, flush_pend.
  - State goes to S_FILL.
  - Any in-flight byte is discarded.
  - While reset is low, o_rd_en=0.
- Pop rule: o_rd_en = i_rd_rst_n & ~i_empty & (state==S_FILL) & (acc_cnt<LANES) & ~flush_pend. It is combinational, so it drops in the same cycle i_empty rises.
- Counters:
  - acc_cnt increments on every pop and counts issued pops, not landed data.
  - inflight=1 in the cycle after a pop. In that cycle i_rd_data is captured into lane (number of landed bytes), lane 0 = bits [DATASIZE-1:0].
- Word completion: a word is complete when acc_cnt==LANES and the last byte is landing this cycle, or has already landed.
  - If ~o_word_valid | i_word_ready, the word (including the landing byte, bypassed) loads o_word at the edge.
  - On that load: o_word_bytes=LANES, o_word_valid=1, acc_cnt=0.
  - Otherwise the state goes to S_HOLD.
  - No pop is allowed in the landing cycle. Sustained throughput is LANES entries per LANES+1 cycles.
- S_HOLD:
  - No pops.
  - The accumulator is frozen.
  - The state moves to S_FILL on the edge where the transfer occurs (sink handshake frees o_word).
- Output handshake:
  - o_word_valid clears on an edge with i_word_ready=1 unless a new word loads on the same edge.
  - o_word and o_word_bytes stay stable while valid and not ready.
- Flush:
  - i_flush sets flush_pend; new pops stop immediately, including in the i_flush cycle.
  - The state becomes S_FLUSH once no byte is in flight.
  - In S_FLUSH, with landed count k>0 and the output free: o_word loads lanes 0..k-1 with upper lanes 0, o_word_bytes=k, o_word_valid=1, o_flush_done pulses on the same edge, acc_cnt=0, state returns to S_FILL.
  - With k=0: no word is produced; o_flush_done pulses on the next edge and the state returns to S_FILL.
  - If the output is busy, the block waits in S_FLUSH.
- i_flush received while flush_pend=1 is ignored.
- i_flush arriving on the same edge a full word completes: the full word is emitted first, then the flush completes with k=0.
- acc_cnt never exceeds LANES. The lane index wraps to 0 after each transfer.

Test Plan:
1. Reset check: hold i_rd_rst_n=0 for 3 edges with i_empty=0 and i_word_ready=1 -> o_rd_en=0, o_word_valid=0, o_word=0, o_flush_done=0 throughout.
2. Basic pack: FIFO holds 0x11,0x22,0x33,0x44, i_word_ready=1.
   - Required: o_rd_en high cycles 0-3 and low in cycle 4.
   - Required: o_word_valid in cycle 5 with o_word=0x44332211, o_word_bytes=4.
3. Backpressure: 8 entries 0x01..0x08, i_word_ready=0.
   - Required: o_word=0x04030201 held stable; 4 more pops occur, then o_rd_en=0 (S_HOLD).
   - Raise ready for one cycle -> o_word=0x08070605 loads on that edge.
4. Partial flush: pop 0xA1,0xB2,0xC3, i_empty=1, pulse i_flush -> o_word=0x00C3B2A1, o_word_bytes=3, o_word_valid=1 and o_flush_done pulse on the same edge.
5. Empty flush: acc_cnt=0, pulse i_flush -> no o_word_valid; o_flush_done pulses once on the following edge.
6. Mid-operation events:
   - i_empty rises after 2 pops -> o_rd_en=0 in the same cycle; resumes when i_empty falls; the word still assembles in order.
   - Assert reset with 2 bytes accumulated -> next word after reset contains only post-reset data.

Source files
------------

// File: rtl/fifo_rd_unpacker.sv
// Read-side FIFO consumer: pops DATASIZE-bit entries and packs LANES of them
// into one wide word handed to a valid/ready sink, with flush of partial words.
module fifo_rd_unpacker #(
    parameter int DATASIZE = 8,
    parameter int LANES    = 4,
    parameter int CNTW     = 3
) (
    input  logic                        i_rd_clk,
    input  logic                        i_rd_rst_n,
    input  logic                        i_empty,
    input  logic [DATASIZE-1:0]         i_rd_data,
    output logic                        o_rd_en,
    output logic [DATASIZE*LANES-1:0]   o_word,
    output logic [CNTW-1:0]             o_word_bytes,
    output logic                        o_word_valid,
    input  logic                        i_word_ready,
    input  logic                        i_flush,
    output logic                        o_flush_done
);

    localparam int WORDW = DATASIZE * LANES;
    localparam logic [CNTW-1:0]  CNT_ZERO  = {CNTW{1'b0}};
    localparam logic [CNTW-1:0]  CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]  CNT_LANES = CNTW'(LANES);
    localparam logic [WORDW-1:0] WORD_ZERO = {WORDW{1'b0}};

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [WORDW-1:0]  acc_r, acc_s;
    logic [CNTW-1:0]   acc_cnt_r, acc_cnt_s;
    logic              inflight_r;
    logic              flush_pend_r, flush_pend_s;
    logic [WORDW-1:0]  word_s;
    logic [CNTW-1:0]   bytes_s;
    logic              valid_s;
    logic              done_s;
    logic [CNTW-1:0]   lane_s;
    logic              out_free_s;
    logic              pop_s;

    // acc_cnt counts issued pops, so the landing lane lags it by the in-flight byte
    assign lane_s     = acc_cnt_r - {{(CNTW-1){1'b0}}, inflight_r};
    assign out_free_s = ~o_word_valid | i_word_ready;
    assign pop_s      = i_rd_rst_n & ~i_empty & (state_r == S_FILL) &
                        (acc_cnt_r < CNT_LANES) & ~flush_pend_r & ~i_flush;
    assign o_rd_en    = pop_s;

    // Next-state, accumulator and output-word computation
    always_comb begin
        state_s      = state_r;
        acc_s        = acc_r;
        acc_cnt_s    = acc_cnt_r;
        flush_pend_s = flush_pend_r | i_flush;
        word_s       = o_word;
        bytes_s      = o_word_bytes;
        valid_s      = o_word_valid & ~i_word_ready;
        done_s       = 1'b0;

        // Landing byte is merged here so a completing word can bypass it out
        if (inflight_r) begin
            acc_s[lane_s*DATASIZE +: DATASIZE] = i_rd_data;
        end else begin
            acc_s = acc_r;
        end

        if (pop_s) begin
            acc_cnt_s = acc_cnt_r + CNT_ONE;
        end else begin
            acc_cnt_s = acc_cnt_r;
        end

        case (state_r)
            S_FILL: begin
                if (acc_cnt_r == CNT_LANES) begin
                    if (out_free_s) begin
                        word_s    = acc_s;
                        bytes_s   = CNT_LANES;
                        valid_s   = 1'b1;
                        acc_s     = WORD_ZERO;
                        acc_cnt_s = CNT_ZERO;
                    end else begin
                        state_s = S_HOLD;
                    end
                end else if (flush_pend_s) begin
                    state_s = S_FLUSH;
                end else begin
                    state_s = S_FILL;
                end
            end
            S_HOLD: begin
                if (out_free_s) begin
                    word_s    = acc_s;
                    bytes_s   = CNT_LANES;
                    valid_s   = 1'b1;
                    acc_s     = WORD_ZERO;
                    acc_cnt_s = CNT_ZERO;
                    state_s   = S_FILL;
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_FLUSH: begin
                if (acc_cnt_r == CNT_ZERO) begin
                    done_s       = 1'b1;
                    flush_pend_s = 1'b0;
                    state_s      = S_FILL;
                end else if (out_free_s) begin
                    // Unused upper lanes are already zero since the accumulator clears on every load
                    word_s       = acc_s;
                    bytes_s      = acc_cnt_r;
                    valid_s      = 1'b1;
                    done_s       = 1'b1;
                    acc_s        = WORD_ZERO;
                    acc_cnt_s    = CNT_ZERO;
                    flush_pend_s = 1'b0;
                    state_s      = S_FILL;
                end else begin
                    state_s = S_FLUSH;
                end
            end
            default: begin
                state_s = S_FILL;
            end
        endcase
    end

    // State, accumulator and output registers with synchronous reset
    always_ff @(posedge i_rd_clk) begin
        if (!i_rd_rst_n) begin
            state_r      <= S_FILL;
            acc_r        <= WORD_ZERO;
            acc_cnt_r    <= CNT_ZERO;
            inflight_r   <= 1'b0;
            flush_pend_r <= 1'b0;
            o_word       <= WORD_ZERO;
            o_word_bytes <= CNT_ZERO;
            o_word_valid <= 1'b0;
            o_flush_done <= 1'b0;
        end else begin
            state_r      <= state_s;
            acc_r        <= acc_s;
            acc_cnt_r    <= acc_cnt_s;
            inflight_r   <= pop_s;
            flush_pend_r <= flush_pend_s;
            o_word       <= word_s;
            o_word_bytes <= bytes_s;
            o_word_valid <= valid_s;
            o_flush_done <= done_s;
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Directed bench for fifo_rd_unpacker: a queue stands in for the FIFO read
// side, and each vector compares outputs against hand-computed values.
module tb_fifo_rd_unpacker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_empty;
    logic [7:0]  i_rd_data;
    logic        o_rd_en;
    logic [31:0] o_word;
    logic [2:0]  o_word_bytes;
    logic        o_word_valid;
    logic        i_word_ready;
    logic        i_flush;
    logic        o_flush_done;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] q[$];
    bit hold_empty = 1'b0;

    fifo_rd_unpacker #(.DATASIZE(8), .LANES(4), .CNTW(3)) dut (
        .i_rd_clk     (clk),
        .i_rd_rst_n   (rst_n),
        .i_empty      (i_empty),
        .i_rd_data    (i_rd_data),
        .o_rd_en      (o_rd_en),
        .o_word       (o_word),
        .o_word_bytes (o_word_bytes),
        .o_word_valid (o_word_valid),
        .i_word_ready (i_word_ready),
        .i_flush      (i_flush),
        .o_flush_done (o_flush_done)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_empty();
        i_empty = hold_empty || (q.size() == 0);
    endtask

    // One clock: the FIFO model pops on the edge if rd_en was high, data valid next cycle
    task automatic tick();
        bit p;
        #1;
        p = o_rd_en;
        @(posedge clk);
        #1;
        if (p) begin
            if (q.size() > 0) i_rd_data = q.pop_front();
            else              i_rd_data = 8'hEE;
        end
        set_empty();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        i_empty      = 1'b0;
        i_rd_data    = 8'h00;
        i_word_ready = 1'b1;
        i_flush      = 1'b0;

        // 1. reset holds everything quiet even with a non-empty FIFO
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_eq("rst_rd_en", o_rd_en, 1'b0);
            chk_eq("rst_valid", o_word_valid, 1'b0);
            chk_eq("rst_word", o_word, 32'h0);
            chk_eq("rst_done", o_flush_done, 1'b0);
        end
        rst_n = 1'b1;
        set_empty();
        #1;

        // 2. basic pack
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        set_empty();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_eq("t2_rd_en", o_rd_en, 1'b1);
            tick();
        end
        chk_eq("t2_rd_en_c4", o_rd_en, 1'b0);
        chk_eq("t2_valid_c4", o_word_valid, 1'b0);
        tick();
        chk_eq("t2_valid", o_word_valid, 1'b1);
        chk_eq("t2_word", o_word, 32'h44332211);
        chk_eq("t2_bytes", o_word_bytes, 3'd4);
        tick();
        chk_eq("t2_valid_clr", o_word_valid, 1'b0);

        // 3. backpressure, then a trailing single byte flushed out
        i_word_ready = 1'b0;
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        set_empty();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_eq("t3_rd_en_a", o_rd_en, 1'b1);
            tick();
        end
        chk_eq("t3_gap", o_rd_en, 1'b0);
        tick();
        chk_eq("t3_valid1", o_word_valid, 1'b1);
        chk_eq("t3_word1", o_word, 32'h04030201);
        for (int i = 0; i < 4; i++) begin
            chk_eq("t3_rd_en_b", o_rd_en, 1'b1);
            chk_eq("t3_word1_stable", o_word, 32'h04030201);
            tick();
        end
        chk_eq("t3_rd_en_full", o_rd_en, 1'b0);
        tick();
        repeat (2) begin
            chk_eq("t3_hold_rd_en", o_rd_en, 1'b0);
            chk_eq("t3_hold_word", o_word, 32'h04030201);
            chk_eq("t3_hold_valid", o_word_valid, 1'b1);
            tick();
        end
        i_word_ready = 1'b1;
        tick();
        i_word_ready = 1'b0;
        #1;
        chk_eq("t3_word2", o_word, 32'h08070605);
        chk_eq("t3_valid2", o_word_valid, 1'b1);
        chk_eq("t3_bytes2", o_word_bytes, 3'd4);
        chk_eq("t3_refill", o_rd_en, 1'b1);
        i_word_ready = 1'b1;
        tick();
        chk_eq("t3_valid2_clr", o_word_valid, 1'b0);
        i_flush = 1'b1;
        #1;
        chk_eq("t3_flush_rd_en", o_rd_en, 1'b0);
        tick();
        i_flush = 1'b0;
        #1;
        chk_eq("t3_fl_done_early", o_flush_done, 1'b0);
        tick();
        chk_eq("t3_fl_word", o_word, 32'h00000009);
        chk_eq("t3_fl_bytes", o_word_bytes, 3'd1);
        chk_eq("t3_fl_valid", o_word_valid, 1'b1);
        chk_eq("t3_fl_done", o_flush_done, 1'b1);
        tick();
        chk_eq("t3_fl_done_clr", o_flush_done, 1'b0);

        // 4. partial flush of three bytes
        q = '{8'hA1, 8'hB2, 8'hC3};
        set_empty();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_eq("t4_rd_en", o_rd_en, 1'b1);
            tick();
        end
        chk_eq("t4_rd_en_empty", o_rd_en, 1'b0);
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        #1;
        chk_eq("t4_valid_early", o_word_valid, 1'b0);
        chk_eq("t4_done_early", o_flush_done, 1'b0);
        tick();
        chk_eq("t4_word", o_word, 32'h00C3B2A1);
        chk_eq("t4_bytes", o_word_bytes, 3'd3);
        chk_eq("t4_valid", o_word_valid, 1'b1);
        chk_eq("t4_done", o_flush_done, 1'b1);
        tick();
        chk_eq("t4_done_clr", o_flush_done, 1'b0);
        chk_eq("t4_valid_clr", o_word_valid, 1'b0);

        // 5. empty flush
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        #1;
        chk_eq("t5_done_early", o_flush_done, 1'b0);
        chk_eq("t5_valid_a", o_word_valid, 1'b0);
        tick();
        chk_eq("t5_done", o_flush_done, 1'b1);
        chk_eq("t5_valid_b", o_word_valid, 1'b0);
        tick();
        chk_eq("t5_done_clr", o_flush_done, 1'b0);

        // 6a. empty rises mid-word
        q = '{8'h55, 8'h66, 8'h77, 8'h88};
        set_empty();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk_eq("t6a_rd_en_a", o_rd_en, 1'b1);
            tick();
        end
        hold_empty = 1'b1;
        set_empty();
        #1;
        chk_eq("t6a_drop", o_rd_en, 1'b0);
        tick();
        chk_eq("t6a_stay_low", o_rd_en, 1'b0);
        tick();
        hold_empty = 1'b0;
        set_empty();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk_eq("t6a_rd_en_b", o_rd_en, 1'b1);
            tick();
        end
        chk_eq("t6a_rd_en_full", o_rd_en, 1'b0);
        tick();
        chk_eq("t6a_word", o_word, 32'h88776655);
        chk_eq("t6a_valid", o_word_valid, 1'b1);
        tick();

        // 6b. reset with two bytes accumulated
        q = '{8'h10, 8'h20, 8'h30, 8'h40};
        set_empty();
        #1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_eq("t6b_rst_rd_en", o_rd_en, 1'b0);
        tick();
        tick();
        chk_eq("t6b_rst_valid", o_word_valid, 1'b0);
        rst_n = 1'b1;
        q.push_back(8'h50);
        q.push_back(8'h60);
        set_empty();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_eq("t6b_rd_en", o_rd_en, 1'b1);
            tick();
        end
        chk_eq("t6b_rd_en_full", o_rd_en, 1'b0);
        tick();
        chk_eq("t6b_word", o_word, 32'h60504030);
        chk_eq("t6b_bytes", o_word_bytes, 3'd4);
        chk_eq("t6b_valid", o_word_valid, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
